// File: rtl/anabellek_kopru.sv
// Cache-line bridge: arbitrates instruction/data line requests onto a 32-bit main-memory word bus.
// Optional ANABELLEK_KOPRU_RR_EN selects round-robin arbitration instead of fixed data-port priority.
module anabellek_kopru #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned OFS_W      = $clog2(LINE_WORDS) + 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    g_istek_i,
    input  logic [31:0]             g_adres_i,
    input  logic                    b_istek_i,
    input  logic                    b_yaz_i,
    input  logic [31:0]             b_adres_i,
    input  logic [32*LINE_WORDS-1:0] b_yaz_veri_i,
    output logic [32*LINE_WORDS-1:0] okunan_veri_obegi_o,
    output logic                    g_hazir_o,
    output logic                    b_hazir_o,
    output logic                    musait_o,
    output logic                    iomem_valid_o,
    input  logic                    iomem_ready_i,
    output logic [31:0]             adres_o,
    output logic [31:0]             yaz_veri_o,
    output logic [3:0]              wr_strb_o,
    input  logic [31:0]             anabellekten_veri_i
);

    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        YAZ   = 2'd2,
        BITTI = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              grant_b_c, grant_g_c, prefer_b_c;
    logic              beat_done_c, last_beat_c;
    logic [BEAT_W-1:0] beat_q, beat_nxt_c;
    logic [31:0]       req_adres_c;
    logic              port_b_q;
    logic              unused_ok;

`ifdef ANABELLEK_KOPRU_RR_EN
    // Pointer favours the port that was not granted last; reset favours the data port.
    logic prefer_b_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)          prefer_b_q <= 1'b1;
        else if (grant_b_c) prefer_b_q <= 1'b0;
        else if (grant_g_c) prefer_b_q <= 1'b1;
    end
    assign prefer_b_c = prefer_b_q;
`else
    assign prefer_b_c = 1'b1;
`endif

    assign beat_done_c = iomem_valid_o & iomem_ready_i;
    assign last_beat_c = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign beat_nxt_c  = beat_q + BEAT_W'(1);
    assign req_adres_c = grant_b_c ? b_adres_i : g_adres_i;
    // Offset bits inside the line are deliberately dropped.
    assign unused_ok   = ^req_adres_c[OFS_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= BOSTA;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_b_c = 1'b0;
        grant_g_c = 1'b0;
        case (state_q)
            BOSTA: begin
                grant_b_c = b_istek_i & (~g_istek_i | prefer_b_c);
                grant_g_c = g_istek_i & ~grant_b_c;
                if (grant_b_c)      state_d = b_yaz_i ? YAZ : OKU;
                else if (grant_g_c) state_d = OKU;
            end
            OKU, YAZ: begin
                if (beat_done_c && last_beat_c) state_d = BITTI;
            end
            BITTI:   state_d = BOSTA;
            default: state_d = BOSTA;
        endcase
    end

    // Burst datapath: address/data beats, read-line assembly and completion pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            musait_o            <= 1'b0;
            iomem_valid_o       <= 1'b0;
            adres_o             <= '0;
            yaz_veri_o          <= '0;
            wr_strb_o           <= '0;
            g_hazir_o           <= 1'b0;
            b_hazir_o           <= 1'b0;
            okunan_veri_obegi_o <= '0;
            beat_q              <= '0;
            port_b_q            <= 1'b0;
        end else begin
            musait_o  <= (state_d == BOSTA);
            g_hazir_o <= 1'b0;
            b_hazir_o <= 1'b0;
            case (state_q)
                BOSTA: begin
                    if (grant_b_c | grant_g_c) begin
                        iomem_valid_o <= 1'b1;
                        adres_o       <= {req_adres_c[31:OFS_W], OFS_W'(0)};
                        beat_q        <= '0;
                        port_b_q      <= grant_b_c;
                        if (grant_b_c & b_yaz_i) begin
                            wr_strb_o  <= 4'hF;
                            yaz_veri_o <= b_yaz_veri_i[31:0];
                        end else begin
                            wr_strb_o  <= 4'h0;
                            yaz_veri_o <= '0;
                        end
                    end
                end
                OKU, YAZ: begin
                    if (beat_done_c) begin
                        if (state_q == OKU)
                            okunan_veri_obegi_o[{beat_q, 5'd0} +: 32] <= anabellekten_veri_i;
                        if (last_beat_c) begin
                            iomem_valid_o <= 1'b0;
                            g_hazir_o     <= ~port_b_q;
                            b_hazir_o     <= port_b_q;
                        end else begin
                            beat_q  <= beat_nxt_c;
                            adres_o <= adres_o + 32'd4;
                            if (state_q == YAZ)
                                yaz_veri_o <= b_yaz_veri_i[{beat_nxt_c, 5'd0} +: 32];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_anabellek_kopru.sv
// Self-checking bench for anabellek_kopru: a 4-word and an 8-word instance driven by a
// behavioural memory/requester model with randomized data, addresses and ready patterns.
module tb_anabellek_kopru;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, sel8;
    logic         g_istek, b_istek, b_yaz, ready;
    logic [31:0]  g_adres, b_adres, mdata;
    logic [255:0] b_wd;

    logic [127:0] line4;
    logic [255:0] line8;
    logic         gh4, bh4, mus4, v4, gh8, bh8, mus8, v8;
    logic [31:0]  ad4, yv4, ad8, yv8;
    logic [3:0]   st4, st8;

    logic [255:0] o_line;
    logic         o_gh, o_bh, o_mus, o_valid;
    logic [31:0]  o_adres, o_yaz;
    logic [3:0]   o_strb;

    int           tests_run = 0;
    int           fails = 0;
    bit           last_was_b;
    logic [255:0] last_line [2];

    anabellek_kopru #(.LINE_WORDS(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .g_istek_i(g_istek & ~sel8), .g_adres_i(g_adres),
        .b_istek_i(b_istek & ~sel8), .b_yaz_i(b_yaz), .b_adres_i(b_adres),
        .b_yaz_veri_i(b_wd[127:0]),
        .okunan_veri_obegi_o(line4), .g_hazir_o(gh4), .b_hazir_o(bh4), .musait_o(mus4),
        .iomem_valid_o(v4), .iomem_ready_i(ready & ~sel8), .adres_o(ad4),
        .yaz_veri_o(yv4), .wr_strb_o(st4), .anabellekten_veri_i(mdata)
    );

    anabellek_kopru #(.LINE_WORDS(8)) dut8 (
        .clk_i(clk), .rst_i(rst),
        .g_istek_i(g_istek & sel8), .g_adres_i(g_adres),
        .b_istek_i(b_istek & sel8), .b_yaz_i(b_yaz), .b_adres_i(b_adres),
        .b_yaz_veri_i(b_wd),
        .okunan_veri_obegi_o(line8), .g_hazir_o(gh8), .b_hazir_o(bh8), .musait_o(mus8),
        .iomem_valid_o(v8), .iomem_ready_i(ready & sel8), .adres_o(ad8),
        .yaz_veri_o(yv8), .wr_strb_o(st8), .anabellekten_veri_i(mdata)
    );

    always_comb begin
        o_line  = sel8 ? line8 : {128'b0, line4};
        o_gh    = sel8 ? gh8 : gh4;
        o_bh    = sel8 ? bh8 : bh4;
        o_mus   = sel8 ? mus8 : mus4;
        o_valid = sel8 ? v8 : v4;
        o_adres = sel8 ? ad8 : ad4;
        o_yaz   = sel8 ? yv8 : yv4;
        o_strb  = sel8 ? st8 : st4;
    end

    // One complete line transfer with the bench acting as requester and main memory.
    // mode 0: ready every cycle, 1: every other cycle, 2: random. exp_lat 0 = derive from waits.
    task automatic do_xfer(input bit port_b, input bit wr, input logic [31:0] addr,
                           input logic [255:0] wd, input int mode, input int exp_lat);
        int lw, k, cyc, vcyc, want_lat;
        bit done, phase, rdy;
        logic [31:0]  base;
        logic [255:0] exp_line;
        lw       = sel8 ? 8 : 4;
        base     = addr & (sel8 ? 32'hFFFF_FFE0 : 32'hFFFF_FFF0);
        exp_line = last_line[sel8];
        k = 0; cyc = 1; vcyc = 0; done = 0; phase = 0;
        tests_run++;
        if (o_mus !== 1'b1) begin fails++; $display("FAIL idle_before_req: musait=%b want 1", o_mus); end
        if (port_b) begin b_istek = 1; b_yaz = wr; b_adres = addr; b_wd = wd; end
        else begin g_istek = 1; g_adres = addr; end
        while (!done && cyc < 300) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            ready = 0;
            tests_run++;
            if (o_gh & o_bh) begin fails++; $display("FAIL hazir_exclusive: both hazir high"); end
            if (o_gh | o_bh) begin
                want_lat = (exp_lat > 0) ? exp_lat : 2 + vcyc;
                tests_run++;
                if ({o_gh, o_bh} !== {~port_b, port_b}) begin
                    fails++; $display("FAIL hazir_port: g/b=%b%b want %b%b", o_gh, o_bh, ~port_b, port_b);
                end
                tests_run++;
                if (k != lw) begin fails++; $display("FAIL beat_count: %0d want %0d", k, lw); end
                tests_run++;
                if (o_valid !== 1'b0) begin fails++; $display("FAIL valid_in_bitti: %b want 0", o_valid); end
                tests_run++;
                if (cyc != want_lat) begin fails++; $display("FAIL latency: %0d want %0d", cyc, want_lat); end
                tests_run++;
                if (o_line !== exp_line) begin fails++; $display("FAIL line: got %h want %h", o_line, exp_line); end
                g_istek = 0; b_istek = 0;
                ready = 1; mdata = $urandom;     // stray ready while idle must be ignored
                done = 1;
            end else if (o_valid === 1'b1 && k < lw) begin
                vcyc++;
                tests_run++;
                if (o_adres !== base + 32'(4 * k)) begin
                    fails++; $display("FAIL beat_addr k=%0d: %h want %h", k, o_adres, base + 32'(4 * k));
                end
                tests_run++;
                if (o_strb !== (wr ? 4'hF : 4'h0)) begin
                    fails++; $display("FAIL wr_strb: %h want %h", o_strb, wr ? 4'hF : 4'h0);
                end
                if (wr) begin
                    tests_run++;
                    if (o_yaz !== wd[32*k +: 32]) begin
                        fails++; $display("FAIL wr_data k=%0d: %h want %h", k, o_yaz, wd[32*k +: 32]);
                    end
                end
                case (mode)
                    0:       rdy = 1;
                    1:       begin rdy = phase; phase = ~phase; end
                    default: rdy = ($urandom_range(2) != 0);
                endcase
                if (rdy) begin
                    ready = 1; mdata = $urandom;
                    if (!wr) exp_line[32*k +: 32] = mdata;
                    k++;
                end
            end else begin
                tests_run++; fails++;
                $display("FAIL burst_flow: valid=%b k=%0d without hazir", o_valid, k);
                g_istek = 0; b_istek = 0;
                done = 1;
            end
        end
        if (!done) begin
            tests_run++; fails++;
            $display("FAIL timeout: no hazir after %0d cycles", cyc);
            g_istek = 0; b_istek = 0;
        end
        @(posedge clk); @(negedge clk);
        ready = 0;
        tests_run++;
        if ({o_valid, o_gh, o_bh, o_mus} !== 4'b0001) begin
            fails++; $display("FAIL after_bitti: valid/g/b/musait=%b want 0001", {o_valid, o_gh, o_bh, o_mus});
        end
        tests_run++;
        if (o_line !== exp_line) begin fails++; $display("FAIL line_hold: got %h want %h", o_line, exp_line); end
        last_line[sel8] = exp_line;
        if (!sel8) last_was_b = port_b;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({o_mus, o_valid, o_gh, o_bh, o_strb} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl: mus/valid/g/b/strb=%b want 0", {o_mus, o_valid, o_gh, o_bh, o_strb});
        end
        tests_run++;
        if ({o_adres, o_yaz} !== 64'h0) begin fails++; $display("FAIL reset_bus: %h want 0", {o_adres, o_yaz}); end
        tests_run++;
        if (o_line !== 256'h0) begin fails++; $display("FAIL reset_line: %h want 0", o_line); end
        rst = 0;
        @(posedge clk); @(negedge clk);
        tests_run++;
        if (o_mus !== 1'b1) begin fails++; $display("FAIL reset_release: musait=%b want 1", o_mus); end
        last_was_b = 0;
        last_line[0] = '0; last_line[1] = '0;
    endtask

    task automatic test_read_basic();
        do_xfer(0, 0, 32'h0000_1008, '0, 0, 6);
    endtask

    task automatic test_write();
        do_xfer(1, 1, 32'h0000_2000, {128'h0, 128'h4444_4444_3333_3333_2222_2222_1111_1111}, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            bit pb, wr;
            logic [255:0] wd;
            pb = 1'($urandom);
            wr = pb & 1'($urandom);
            for (int w = 0; w < 8; w++) wd[32*w +: 32] = $urandom;
            do_xfer(pb, wr, $urandom, wd, int'($urandom_range(2)), 0);
        end
    endtask

    // Both ports request in the same idle cycle; order must follow the arbitration policy.
    task automatic test_arbitration();
        for (int rep = 0; rep < 2; rep++) begin
            bit exp_first_b, order0, order1;
            int n, cyc;
`ifdef ANABELLEK_KOPRU_RR_EN
            exp_first_b = ~last_was_b;
`else
            exp_first_b = 1'b1;
`endif
            g_adres = $urandom; b_adres = $urandom; b_yaz = 0;
            g_istek = 1; b_istek = 1;
            n = 0; cyc = 0; order0 = 0; order1 = 0;
            while (n < 2 && cyc < 100) begin
                @(posedge clk); @(negedge clk);
                cyc++;
                ready = o_valid; mdata = $urandom;
                if (o_gh | o_bh) begin
                    if (n == 0) order0 = o_bh; else order1 = o_bh;
                    n++;
                    if (o_bh) b_istek = 0;
                    if (o_gh) g_istek = 0;
                    ready = 0;
                end
            end
            ready = 0; g_istek = 0; b_istek = 0;
            @(posedge clk); @(negedge clk);
            tests_run++;
            if (n != 2) begin fails++; $display("FAIL arb_count rep%0d: %0d hazir want 2", rep, n); end
            tests_run++;
            if (order0 !== exp_first_b) begin
                fails++; $display("FAIL arb_first rep%0d: b=%b want %b", rep, order0, exp_first_b);
            end
            tests_run++;
            if (order1 !== ~exp_first_b) begin
                fails++; $display("FAIL arb_second rep%0d: b=%b want %b", rep, order1, ~exp_first_b);
            end
            last_was_b = ~exp_first_b;
        end
    endtask

    task automatic test_reset_mid();
        int k, cyc;
        k = 0; cyc = 0;
        g_adres = $urandom; g_istek = 1;
        while (k < 2 && cyc < 20) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            ready = 0;
            if (o_valid) begin ready = 1; mdata = $urandom; k++; end
        end
        @(posedge clk); @(negedge clk);
        tests_run++;
        if (k != 2) begin fails++; $display("FAIL mid_beats: %0d want 2", k); end
        ready = 0; rst = 1; g_istek = 0;
        @(posedge clk); @(negedge clk);
        tests_run++;
        if ({o_valid, o_gh, o_bh, o_mus} !== 4'b0000) begin
            fails++; $display("FAIL mid_reset: valid/g/b/musait=%b want 0000", {o_valid, o_gh, o_bh, o_mus});
        end
        tests_run++;
        if (o_line !== 256'h0) begin fails++; $display("FAIL mid_line: %h want 0", o_line); end
        rst = 0;
        @(posedge clk); @(negedge clk);
        tests_run++;
        if ({o_valid, o_gh, o_bh, o_mus} !== 4'b0001) begin
            fails++; $display("FAIL mid_release: valid/g/b/musait=%b want 0001", {o_valid, o_gh, o_bh, o_mus});
        end
        last_was_b = 0;
        last_line[0] = '0; last_line[1] = '0;
    endtask

    task automatic test_line8();
        logic [255:0] wd;
        sel8 = 1;
        do_xfer(0, 0, 32'h0000_3010, '0, 0, 10);
        for (int w = 0; w < 8; w++) wd[32*w +: 32] = $urandom;
        do_xfer(1, 1, $urandom, wd, 2, 0);
        do_xfer(1, 0, $urandom, '0, 2, 0);
        sel8 = 0;
    endtask

    initial begin
        rst = 1; sel8 = 0; ready = 0;
        g_istek = 0; b_istek = 0; b_yaz = 0;
        g_adres = '0; b_adres = '0; b_wd = '0; mdata = '0;
        test_reset();
        test_read_basic();
        test_write();
        test_random();
        test_arbitration();
        test_reset_mid();
        test_line8();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/anabellek_kopru.md
ANABELLEK_KOPRU -- requirements
Module: anabellek_kopru

Interface
REQ-001 SHALL have parameter: LINE_WORDS, default 4, 32-bit words per cache line (power of 2, 2..16).
REQ-002 SHALL have parameter: OFS_W, default $clog2(LINE_WORDS)+2, byte-offset bits inside a line.
REQ-003 SHALL have ports: clk_i  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst_i  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports: g_istek_i  in  1, g_adres_i  in  32  instruction-side line read request/address.
REQ-006 SHALL have ports: b_istek_i  in  1, b_yaz_i  in  1 (1 write, 0 read), b_adres_i  in  32, b_yaz_veri_i  in  32*LINE_WORDS  data-side request.
REQ-007 SHALL have ports: okunan_veri_obegi_o  out  32*LINE_WORDS  assembled read line; g_hazir_o  out  1, b_hazir_o  out  1  completion pulses.
REQ-008 SHALL have ports: musait_o  out  1  idle, no transfer owned.
REQ-009 SHALL have ports: iomem_valid_o  out  1, iomem_ready_i  in  1, adres_o  out  32, yaz_veri_o  out  32, wr_strb_o  out  4, anabellekten_veri_i  in  32  main-memory word bus.

Function
REQ-010 SHALL implement states BOSTA, OKU, YAZ, BITTI; musait_o=1 only in BOSTA.
REQ-011 SHALL sample requests only in BOSTA; requesters hold istek/address/data stable until their hazir pulse.
REQ-012 SHALL grant data port over instruction port when both asserted in the same BOSTA cycle (default arbitration, see REQ-027).
REQ-013 SHALL latch line base = request address with low OFS_W bits cleared; the unaligned low bits are ignored.
REQ-014 SHALL assert iomem_valid_o the cycle after grant, with adres_o = base + 4*k for beat k, k from 0 to LINE_WORDS-1.
REQ-015 SHALL advance k, update adres_o/yaz_veri_o and keep iomem_valid_o high in the cycle after each iomem_ready_i, except after the last beat.
REQ-016 SHALL treat iomem_ready_i while iomem_valid_o=0 as a no-op.
REQ-017 SHALL, on a read, drive wr_strb_o=4'b0000 and store anabellekten_veri_i of beat k into okunan_veri_obegi_o[32k+31:32k] on the ready cycle.
REQ-018 SHALL, on a write, drive wr_strb_o=4'b1111 and yaz_veri_o=b_yaz_veri_i[32k+31:32k]; okunan_veri_obegi_o is unchanged.
REQ-019 SHALL, on the last beat's ready, drop iomem_valid_o next cycle and enter BITTI.
REQ-020 SHALL pulse exactly one of g_hazir_o/b_hazir_o for one cycle while in BITTI, then return to BOSTA; no grant in BITTI.
REQ-021 SHALL hold okunan_veri_obegi_o stable from BITTI until the next read's first ready.
REQ-022 SHALL count beats with a counter of $clog2(LINE_WORDS) bits; no wrap beyond LINE_WORDS-1 in one transfer.
REQ-023 SHALL keep request-to-hazir latency = 1 + sum of per-beat waits + 1 cycles; with ready every cycle, LINE_WORDS+2.

Reset
REQ-024 SHALL, while rst_i=1 at a rising edge, enter BOSTA, clear counter, adres_o=0, yaz_veri_o=0, wr_strb_o=0, iomem_valid_o=0, g_hazir_o=0, b_hazir_o=0, okunan_veri_obegi_o=0, arbitration pointer to data port.
REQ-025 SHALL drive musait_o=0 during reset and 1 from the first cycle after reset release.
REQ-026 SHALL, on reset mid-transfer, abandon the burst: no hazir pulse, partial read data discarded, iomem_valid_o low next cycle.

Configuration
REQ-027 SHALL, with ANABELLEK_KOPRU_RR_EN defined, arbitrate round-robin: on simultaneous requests grant the port not granted last; without it, fixed data-port priority per REQ-012.

Verification
REQ-028 SHALL cover: LINE_WORDS=4, g read 0x0000_1008, ready every cycle -> adres_o 0x1000,0x1004,0x1008,0x100C, g_hazir_o at cycle 6, line = {w3,w2,w1,w0}.
REQ-029 SHALL cover: b write 0x0000_2000, data 128'h4444_4444_3333_3333_2222_2222_1111_1111, ready every other cycle -> yaz_veri_o 0x1111_1111..0x4444_4444, wr_strb_o 4'hF, b_hazir_o once.
REQ-030 SHALL cover: g and b asserted together, both held, RR off -> b served then g; RR_EN on, repeat twice -> grants alternate b,g,b,g.
REQ-031 SHALL cover: rst_i=1 after 2nd read beat -> iomem_valid_o=0 next cycle, no hazir, musait_o=1 after release.
REQ-032 SHALL cover: LINE_WORDS=8, read 0x0000_3010 -> 8 beats 0x3000..0x301C, hazir after last beat, stray iomem_ready_i in BITTI ignored.
